// File: rtl/and_arb_pkg.sv
// Shared types, defaults and the round-robin selection function used by
// the AND-unit arbiter and other shared-resource arbiters.
package and_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 1;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    // First set bit of valid at or after ptr, wrapping modulo n; 0 if none set.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned        ptr,
                                            input int unsigned        n);
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k < n && !found && ((valid >> idx) & MAX_REQ'(1)) != '0) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority select: winner index at or after ptr,
// plus a flag telling whether any requester is valid at all.
module rr_picker
    import and_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win,
    output logic             any_valid
);

    assign win       = ID_W'(rr_pick(MAX_REQ'(valid), 32'(ptr), 32'(N_REQ)));
    assign any_valid = |valid;

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one external combinational AND unit between
// N_REQ requesters: grant, registered operands, registered tagged result.
module and_unit_arbiter
    import and_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       unit_a,
    output logic [WIDTH-1:0]       unit_b,
    input  logic [WIDTH-1:0]       unit_out,
    output logic                   resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ID_W-1:0]        resp_id,
    input  logic                   resp_ready,
    output logic                   busy
);

    logic [1:0]       rst_sync;
    logic             core_rst_n;
    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  pick_win;
    logic             any_valid;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Assert asynchronously, release two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign core_rst_n = rst_sync[1];

    rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .valid    (req_valid),
        .ptr      (ptr),
        .win      (pick_win),
        .any_valid(any_valid)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            win_id     <= '0;
            req_ready  <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        win_id    <= pick_win;
                        req_ready <= N_REQ'(1) << pick_win;
                        state     <= LOAD;
                    end
                end
                // Operands are captured on the same edge that completes the grant handshake.
                LOAD: begin
                    unit_a    <= sel_a;
                    unit_b    <= sel_b;
                    req_ready <= '0;
                    state     <= EXEC;
                end
                EXEC: begin
                    resp_data  <= unit_out;
                    resp_id    <= win_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ptr        <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // A requester must hold req_valid until its grant has been consumed.
    a_req_held: assert property (@(posedge clk) disable iff (!core_rst_n)
        (state == LOAD) |-> req_valid[win_id]);

endmodule

// File: doc/and_unit_arbiter.md
Name: and_unit_arbiter

Overview:
- Shares one combinational two-operand AND unit (ports a, b, out) between N_REQ requesters.
- Round-robin arbitration, valid/ready request handshake, registered operands and a registered result returned with the requester ID.
- Sits between requester blocks and the single and_module instance; the unit itself is instantiated outside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 1, operand/result width in bits (matches the unit's width).
- ID_W, $clog2(N_REQ), requester ID width (derived; not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*WIDTH  operand a, requester i in slice [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand b, same packing as req_a.
- req_ready  out  N_REQ  one-hot grant pulse; request i is consumed this cycle.
- unit_a  out  WIDTH  registered operand to the AND unit's a.
- unit_b  out  WIDTH  registered operand to the AND unit's b.
- unit_out  in  WIDTH  AND unit result (combinational from unit_a/unit_b).
- resp_valid  out  1  result available.
- resp_data  out  WIDTH  registered result.
- resp_id  out  ID_W  index of the requester that owns resp_data.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and the round-robin pointer to 0.
  - req_ready=0, unit_a=0, unit_b=0, resp_valid=0, resp_data=0, resp_id=0, busy=0.
  - Deassertion is synchronised internally with a two-flop release.
- FSM states IDLE, LOAD, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick winner w = first set bit at or after the pointer, wrapping modulo N_REQ.
  - Go to LOAD with w registered.
  - If no request is valid, stay in IDLE.
- LOAD (1 cycle):
  - Register req_a[w] into unit_a and req_b[w] into unit_b.
  - Assert req_ready[w] for exactly this cycle; all other req_ready bits stay 0.
  - Go to EXEC.
- EXEC (1 cycle):
  - Register unit_out into resp_data and w into resp_id.
  - Set resp_valid=1.
  - Go to RESP.
- RESP:
  - Hold resp_valid, resp_data and resp_id stable until resp_ready=1.
  - On the cycle resp_ready=1: resp_valid falls next cycle, the pointer becomes (w+1) mod N_REQ, and the FSM returns to IDLE.
- Latency: request accepted in LOAD (cycle 1 after IDLE sees valid); resp_valid rises cycle 3. Minimum 4 cycles per operation with resp_ready tied high.
- Requester rule:
  - req_valid and operands must stay stable until req_ready.
  - The arbiter samples operands only in LOAD. If req_valid[w] drops before LOAD, the sampled values are still used (protocol violation, flagged by an assertion).
- unit_a/unit_b hold their last values outside LOAD. The unit is never driven with mixed operands from different requesters.
- Fairness: after granting w, requester w has lowest priority. With all requesters continuously valid, grants cycle 0,1,2,...,N_REQ-1,0.
- Pointer wrap: a grant to N_REQ-1 sets the pointer to 0.
- Simultaneous events:
  - A req_valid rising during LOAD/EXEC/RESP waits for IDLE.
  - resp_ready high before resp_valid has no effect.
- Reset mid-operation: the in-flight operation is dropped with no response issued; the requester must re-request.
- busy = (state != IDLE).

Decomposition:
- Package and_arb_pkg holds:
  - the state enum (IDLE, LOAD, EXEC, RESP), 2-bit;
  - default N_REQ/WIDTH constants;
  - the function rr_pick(valid, ptr) returning the winner index.
- One sub-module, rr_picker: combinational round-robin priority select. Inputs are the valid vector and pointer; outputs are the winner index and an any_valid flag. It is reused by later shared-resource arbiters.

Test Plan:
- Single request: req_valid=4'b0001, a=1, b=1, resp_ready=1.
  - Expect req_ready[0] pulse at cycle 1, resp_valid at cycle 3 with resp_data=1 and resp_id=0.
  - Repeat with a=1,b=0 / a=0,b=1 / a=0,b=0; each gives resp_data=0.
- All four valid, operands requester i: a=1, b=(i odd).
  - Expect grant order 0,1,2,3,0 and resp_data 0,1,0,1 with matching resp_id.
  - No req_ready overlap.
- Wrap-around: pointer at 3, only requesters 3 and 0 valid.
  - Expect grant 3 then 0.
  - Then with requester 1 valid, expect grant 1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid.
  - resp_valid, resp_data and resp_id stay stable and no new req_ready occurs.
  - Release, then resp_valid falls next cycle.
- Reset mid-EXEC: pull rst_n low asynchronously.
  - All outputs are 0 immediately and state is IDLE.
  - After release, the pending req_valid[2] gets re-granted with correct result.
- Late arrival: req_valid[1] rises during RESP of requester 0.
  - Granted only after the IDLE following resp_ready, with pointer=1.
